vga_mem_arbiter: RTL and testbench

Single-port memory arbiter for the VGA pixel path. It shares one synchronous 2048×8 character/pixel memory between the display fetch port and a host update port. The display fetch port has absolute priority and a fixed latency. The host port uses a req/ack handshake and is served only on cycles the display leaves free. The arbiter sits between the VGA control stage and the memory instance; the sync bypass depth in the top level is sized from its fixed display latency.

---
 rtl/vga_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one synchronous single-port character/pixel memory
// between the VGA display fetch port and a host update port.
//
// Display fetches have absolute priority and a fixed read latency of RD_LAT+1
// clocks. The host is served only on cycles the display leaves free, and never
// on two consecutive edges.
//
// Build option: define VGA_ARB_BLANK_ONLY_EN to restrict host grants to cycles
// where disp_active = 0 (blanking only). Undefined by default, in which case
// disp_active is ignored.
//
// Host handshake: host_req is held high with host_we/host_addr/host_wdata
// stable until host_ack pulses for one cycle. In the cycle after host_ack the
// host either drops host_req or presents its next request. The arbiter never
// grants in that cycle, so a held request cannot be acked twice. Read data
// returns later on host_rdata with a one-cycle host_rvalid pulse.
//
// dbg_state_o exposes the FSM state: 0 = IDLE, 1 = DISP, 2 = HOST.

module vga_mem_arbiter #(
  parameter int AW     = 11,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  input  logic          disp_active,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state_o
);

  // The tag shift register and the memory model around it only make sense
  // for one or two cycles of memory read latency.
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_rd_lat_check
    $error("vga_mem_arbiter: RD_LAT must be 1 or 2");
  end

  // State records who owns the access issued at the last edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_HOST = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic          mem_we_q,    mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          host_ack_q,  host_ack_d;

  // Owner tags travel alongside the memory access; the tag leaving stage
  // RD_LAT says who the current mem_rdata belongs to.
  logic [RD_LAT:0] disp_tag_q;
  logic [RD_LAT:0] hrd_tag_q;
  logic            disp_tag_d;
  logic            hrd_tag_d;

  logic [DW-1:0] disp_data_q;
  logic          disp_valid_q;
  logic [DW-1:0] host_rdata_q;
  logic          host_rvalid_q;

  logic host_ok;

`ifdef VGA_ARB_BLANK_ONLY_EN
  // Host writes during the visible region would tear the picture.
  assign host_ok = ~disp_active;
`else
  logic unused_disp_active;
  assign unused_disp_active = disp_active;
  assign host_ok            = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next owner: display first, then host unless it owned the last edge.
  always_comb begin
    state_d = ST_IDLE;
    if (disp_req) begin
      state_d = ST_DISP;
    end else if (host_req && (state_q != ST_HOST) && host_ok) begin
      state_d = ST_HOST;
    end
  end

  // Memory-port values and tags that go with the chosen owner.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    host_ack_d  = 1'b0;
    disp_tag_d  = 1'b0;
    hrd_tag_d   = 1'b0;
    case (state_d)
      ST_DISP: begin
        mem_addr_d = disp_addr;
        disp_tag_d = 1'b1;
      end
      ST_HOST: begin
        mem_addr_d  = host_addr;
        mem_we_d    = host_we;
        mem_wdata_d = host_wdata;
        host_ack_d  = 1'b1;
        hrd_tag_d   = ~host_we;
      end
      default: begin
      end
    endcase
  end

  // Registered memory port and host acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      host_ack_q  <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      host_ack_q  <= host_ack_d;
    end
  end

  // Owner tag pipeline; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_tag_q <= '0;
      hrd_tag_q  <= '0;
    end else begin
      disp_tag_q <= {disp_tag_q[RD_LAT-1:0], disp_tag_d};
      hrd_tag_q  <= {hrd_tag_q[RD_LAT-1:0], hrd_tag_d};
    end
  end

  // Steer returning read data to its owner and pulse the matching valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      disp_valid_q  <= disp_tag_q[RD_LAT];
      host_rvalid_q <= hrd_tag_q[RD_LAT];
      if (disp_tag_q[RD_LAT]) begin
        disp_data_q <= mem_rdata;
      end
      if (hrd_tag_q[RD_LAT]) begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign host_ack    = host_ack_q;
  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Testbench for vga_mem_arbiter: decision-table vectors, directed multi-cycle
// sequences and randomized traffic checked against a transaction-level model.

module tb_vga_mem_arbiter;

  localparam int AW     = 11;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;
  localparam int LAT    = RD_LAT + 1;
  localparam int DEPTH  = 1 << AW;
`ifdef VGA_ARB_BLANK_ONLY_EN
  localparam bit BLANK_ONLY = 1'b1;
`else
  localparam bit BLANK_ONLY = 1'b0;
`endif

  typedef struct {
    int            at;
    logic [DW-1:0] data;
  } rd_exp_t;

  typedef struct {
    bit            d_req;
    bit            h_req;
    bit            h_we;
    bit            act;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            exp_ack;
    bit            exp_we;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          disp_req, disp_active, disp_valid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          host_req, host_we, host_ack, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  vga_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_active(disp_active),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  function automatic logic [DW-1:0] pattern(input int i);
    return DW'(i * 37 + 11);
  endfunction

  // Synchronous single-port memory, one cycle read latency, read-first.
  logic [DW-1:0] mem [DEPTH];
  bit            env_loaded = 1'b0;
  always @(posedge clk) begin
    if (!env_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pattern(i);
      env_loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  rd_exp_t       disp_q[$];
  rd_exp_t       hrd_q[$];
  bit            last_host;
  bit            exp_ack, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int dv_count = 0, rv_count = 0, ack_count = 0;
  int last_dv_edge = -1, last_rv_edge = -1;
  logic [DW-1:0] last_dv_data, last_rv_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic model_reset();
    disp_q.delete();
    hrd_q.delete();
    last_host = 1'b0;
    exp_ack   = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
  endtask

  task automatic check_all_zero();
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_data", disp_data, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, 0);
  endtask

  // Compare every output against what the model scheduled for this edge.
  task automatic compare();
    rd_exp_t e;
    check("host_ack", host_ack, exp_ack);
    check("mem_we", mem_we, exp_we);
    check("mem_addr", mem_addr, exp_addr);
    if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
    if (host_ack === 1'b1) ack_count++;
    if (disp_q.size() > 0 && disp_q[0].at == edges) begin
      e = disp_q.pop_front();
      check("disp_valid", disp_valid, 1);
      check("disp_data", disp_data, e.data);
    end else begin
      check("disp_valid", disp_valid, 0);
    end
    if (hrd_q.size() > 0 && hrd_q[0].at == edges) begin
      e = hrd_q.pop_front();
      check("host_rvalid", host_rvalid, 1);
      check("host_rdata", host_rdata, e.data);
    end else begin
      check("host_rvalid", host_rvalid, 0);
    end
    if (disp_valid === 1'b1) begin
      dv_count++; last_dv_edge = edges; last_dv_data = disp_data;
    end
    if (host_rvalid === 1'b1) begin
      rv_count++; last_rv_edge = edges; last_rv_data = host_rdata;
    end
  endtask

  // One clock: predict the grant from the current inputs, clock, then compare.
  // Accesses take effect in grant order, so reads see every earlier write.
  task automatic step();
    bit      g_disp, g_host;
    rd_exp_t e;
    g_disp = disp_req;
    g_host = !disp_req && host_req && !last_host && (!BLANK_ONLY || !disp_active);
    exp_ack = g_host;
    exp_we  = g_host && host_we;
    if (g_disp) begin
      exp_addr = disp_addr;
      e.at = edges + 1 + LAT; e.data = ref_mem[disp_addr];
      disp_q.push_back(e);
    end else if (g_host) begin
      exp_addr  = host_addr;
      exp_wdata = host_wdata;
      if (host_we) begin
        ref_mem[host_addr] = host_wdata;
      end else begin
        e.at = edges + 1 + LAT; e.data = ref_mem[host_addr];
        hrd_q.push_back(e);
      end
    end
    last_host = g_host;
    @(posedge clk);
    edges++;
    @(negedge clk);
    compare();
  endtask

  task automatic set_idle();
    disp_req = 1'b0; host_req = 1'b0; disp_active = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (LAT + 2) step();
    check({name, "_disp_q_empty"}, disp_q.size(), 0);
    check({name, "_hrd_q_empty"}, hrd_q.size(), 0);
  endtask

  task automatic new_host();
    host_we    = $urandom_range(0, 1) == 1;
    host_addr  = AW'($urandom_range(0, 31));
    host_wdata = DW'($urandom);
  endtask

  vec_t vecs[6];

  initial begin
    int            e0, a1, a2, acks0, rv0;
    logic [DW-1:0] saved;

    vecs[0] = '{1, 0, 0, 0, 11'h010, 8'h00, 0, 0};
    vecs[1] = '{0, 1, 1, 0, 11'h011, 8'h5A, 1, 1};
    vecs[2] = '{1, 1, 1, 0, 11'h012, 8'h77, 0, 0};
    vecs[3] = '{0, 1, 0, 0, 11'h011, 8'h00, 1, 0};
    vecs[4] = '{0, 0, 1, 0, 11'h013, 8'h99, 0, 0};
    vecs[5] = '{0, 1, 1, 1, 11'h014, 8'hC3, !BLANK_ONLY, !BLANK_ONLY};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i);
    model_reset();
    rst_n = 1'b0;
    set_idle();
    host_we = 1'b0; host_addr = '0; host_wdata = '0; disp_addr = '0;

    // Reset with random inputs: every output stays 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      disp_req    = $urandom_range(0, 1) == 1;
      disp_addr   = AW'($urandom);
      disp_active = $urandom_range(0, 1) == 1;
      host_req    = $urandom_range(0, 1) == 1;
      host_we     = $urandom_range(0, 1) == 1;
      host_addr   = AW'($urandom);
      host_wdata  = DW'($urandom);
      #1 check_all_zero();
    end
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;

    // First display fetch after reset: 2-clock latency, data = mem[0x005].
    disp_req = 1'b1; disp_addr = 11'h005;
    e0 = edges + 1;
    step();
    disp_req = 1'b0;
    step(); step();
    check("first_dv_edge", last_dv_edge, e0 + LAT);
    check("first_dv_data", last_dv_data, pattern(5));

    // Decision table, each vector applied from an idle arbiter.
    for (int i = 0; i < 6; i++) begin
      disp_req = vecs[i].d_req; host_req = vecs[i].h_req; host_we = vecs[i].h_we;
      disp_active = vecs[i].act; disp_addr = vecs[i].addr;
      host_addr = vecs[i].addr; host_wdata = vecs[i].wdata;
      step();
      check("vec_ack", host_ack, vecs[i].exp_ack);
      check("vec_we", mem_we, vecs[i].exp_we);
      set_idle();
      step(); step();
    end
    drain("vec");

    // Display streaming: 640 back-to-back fetches, no gaps.
    dv_count = 0;
    e0 = edges + 1;
    for (int i = 0; i < 640; i++) begin
      disp_req = 1'b1; disp_addr = AW'(i);
      step();
    end
    set_idle();
    drain("stream");
    check("stream_count", dv_count, 640);
    check("stream_last_edge", last_dv_edge, e0 + 639 + LAT);

    // Host write 0xA5 to 0x7FF, then read it back; acks 2 apart.
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h7FF; host_wdata = 8'hA5;
    step();
    check("wr_ack", host_ack, 1);
    a1 = edges;
    host_we = 1'b0;
    step();
    check("holdoff_no_ack", host_ack, 0);
    step();
    check("rd_ack", host_ack, 1);
    a2 = edges;
    check("ack_spacing", a2 - a1, 2);
    host_req = 1'b0;
    step(); step();
    check("rd_rvalid_edge", last_rv_edge, a2 + LAT);
    check("rd_rdata", last_rv_data, 8'hA5);

    // Contention: display holds the memory for 10 cycles.
    acks0 = ack_count;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = AW'(100 + i);
      step();
    end
    check("cont_no_ack", ack_count - acks0, 0);
    disp_req = 1'b0;
    step();
    check("cont_ack", host_ack, 1);
    host_req = 1'b0;
    drain("cont");

    // Blanking gate.
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h040; host_wdata = 8'h3C;
    disp_active = 1'b1;
    step();
    check("blank_first", host_ack, BLANK_ONLY ? 0 : 1);
    if (host_ack !== 1'b1) begin
      step();
      check("blank_hold", host_ack, 0);
      disp_active = 1'b0;
      step();
      check("blank_release", host_ack, 1);
    end
    set_idle();
    drain("blank");

    // Reset during a write ack: mem_we drops at once and nothing commits.
    saved = ref_mem[11'h055];
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h055; host_wdata = 8'hEE;
    step();
    check("abort_we_before", mem_we, 1);
    host_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero();
    #1 rst_n = 1'b1;
    ref_mem[11'h055] = saved;
    model_reset();
    disp_req = 1'b1; disp_addr = 11'h055;
    step();
    disp_req = 1'b0;
    drain("abort");

    // Reset one cycle after a host read ack: no host_rvalid follows.
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h7FF;
    step();
    check("mr_ack", host_ack, 1);
    host_req = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1 check("mr_mem_we", mem_we, 0);
    check("mr_rvalid", host_rvalid, 0);
    #1 rst_n = 1'b1;
    model_reset();
    rv0 = rv_count;
    repeat (4) step();
    check("mr_no_rvalid", rv_count - rv0, 0);

    // Randomized traffic with a protocol-following host.
    set_idle();
    for (int n = 0; n < 1500; n++) begin
      disp_req  = $urandom_range(0, 99) < 45;
      disp_addr = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) disp_active = ~disp_active;
      if (host_req && last_host) begin
        host_req = $urandom_range(0, 1) == 1;
        if (host_req) new_host();
      end else if (!host_req && $urandom_range(0, 2) == 0) begin
        host_req = 1'b1;
        new_host();
      end
      step();
    end
    set_idle();
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
